// File: rtl/alarm_clock_pkg.sv
// Shared types for the alarm clock: sounder states and BCD time width.
// Imported by the buzzer sequencer and its seconds timer.
package alarm_clock_pkg;

  localparam int TIME_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2,
    LOCKOUT = 2'd3
  } alarm_state_t;

endpackage

// File: rtl/alarm_sec_timer.sv
// Seconds counter for ring and snooze intervals.
// done flags the tick that reaches limit; clear wins over tick.
module alarm_sec_timer
  import alarm_clock_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [8:0] limit,
  output logic       done
);

  logic [8:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + 9'd1;
    end
  end

  assign done = tick & (count == limit - 9'd1);

endmodule

// File: rtl/alarm_sound_controller.sv
// Buzzer sequencer: rings on alarm match, handles snooze, stop,
// ring timeout, and locks out re-trigger for the rest of the minute.
module alarm_sound_controller
  import alarm_clock_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              one_second,
  input  logic              alarm_enable,
  input  logic [TIME_W-1:0] current_time,
  input  logic [TIME_W-1:0] alarm_time,
  input  logic              snooze_button,
  input  logic              stop_button,
  output logic              sound_alarm,
  output logic              snoozing,
  output logic [1:0]        snooze_left,
  output logic              alarm_missed
);

  if (RING_SECS < 1 || RING_SECS > 511 ||
      SNOOZE_SECS < 1 || SNOOZE_SECS > 511 ||
      MAX_SNOOZE < 0 || MAX_SNOOZE > 3) begin : g_bad_params
    $error("alarm_sound_controller: parameter out of range");
  end

  localparam logic [8:0] RING_L = 9'(RING_SECS);
  localparam logic [8:0] SNZ_L  = 9'(SNOOZE_SECS);
  localparam logic [1:0] MAX_L  = 2'(MAX_SNOOZE);

  alarm_state_t state, state_n;
  logic [1:0]   used, used_n;
  logic         missed_n;
  logic         match, live, done;
  logic [8:0]   limit;

  assign match = (current_time == alarm_time);
  assign live  = (state == RINGING) || (state == SNOOZE);
  assign limit = (state == SNOOZE) ? SNZ_L : RING_L;

  // Any state change restarts the interval count.
  alarm_sec_timer u_timer (
    .clock (clock),
    .reset (reset),
    .clear (state_n != state),
    .tick  (one_second & live),
    .limit (limit),
    .done  (done)
  );

  always_comb begin
    state_n  = state;
    used_n   = used;
    missed_n = alarm_missed;
    unique case (state)
      IDLE: begin
        if (stop_button) missed_n = 1'b0;
        if (alarm_enable && match) begin
          state_n = RINGING;
          used_n  = 2'd0;
        end
      end
      RINGING: begin
        if (stop_button || !alarm_enable) begin
          state_n = LOCKOUT;
        end else if (snooze_button && used < MAX_L) begin
          state_n = SNOOZE;
          used_n  = used + 2'd1;
        end else if (done) begin
          state_n  = LOCKOUT;
          missed_n = 1'b1;
        end
      end
      SNOOZE: begin
        if (stop_button || !alarm_enable) begin
          state_n = LOCKOUT;
        end else if (done) begin
          state_n = RINGING;
        end
      end
      LOCKOUT: begin
        if (!match) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      used         <= 2'd0;
      sound_alarm  <= 1'b0;
      snoozing     <= 1'b0;
      snooze_left  <= MAX_L;
      alarm_missed <= 1'b0;
    end else begin
      state        <= state_n;
      used         <= used_n;
      sound_alarm  <= (state_n == RINGING);
      snoozing     <= (state_n == SNOOZE);
      snooze_left  <= MAX_L - used_n;
      alarm_missed <= missed_n;
    end
  end

endmodule

// File: tb/tb_alarm_sound_controller.sv
// Self-checking bench: directed scenarios plus randomized run
// against a behavioural model of the alarm sounder.
module tb_alarm_sound_controller;

  localparam int RS = 5;
  localparam int SS = 8;
  localparam int MS = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        one_second;
  logic        alarm_enable;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        snooze_button;
  logic        stop_button;
  logic        sound_alarm;
  logic        snoozing;
  logic [1:0]  snooze_left;
  logic        alarm_missed;

  int checks = 0;
  int errors = 0;

  bit m_ring, m_snz, m_lock, m_missed;
  int m_used, m_secs;

  always #5 clock = ~clock;

  alarm_sound_controller #(
    .RING_SECS   (RS),
    .SNOOZE_SECS (SS),
    .MAX_SNOOZE  (MS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .one_second    (one_second),
    .alarm_enable  (alarm_enable),
    .current_time  (current_time),
    .alarm_time    (alarm_time),
    .snooze_button (snooze_button),
    .stop_button   (stop_button),
    .sound_alarm   (sound_alarm),
    .snoozing      (snoozing),
    .snooze_left   (snooze_left),
    .alarm_missed  (alarm_missed)
  );

  task automatic model_update();
    bit match;
    match = (current_time == alarm_time);
    if (reset) begin
      m_ring = 0; m_snz = 0; m_lock = 0; m_missed = 0;
      m_used = 0; m_secs = 0;
    end else if (m_ring) begin
      if (stop_button || !alarm_enable) begin
        m_ring = 0; m_lock = 1;
      end else if (snooze_button && m_used < MS) begin
        m_ring = 0; m_snz = 1; m_used++; m_secs = 0;
      end else if (one_second) begin
        m_secs++;
        if (m_secs == RS) begin
          m_ring = 0; m_lock = 1; m_missed = 1;
        end
      end
    end else if (m_snz) begin
      if (stop_button || !alarm_enable) begin
        m_snz = 0; m_lock = 1;
      end else if (one_second) begin
        m_secs++;
        if (m_secs == SS) begin
          m_snz = 0; m_ring = 1; m_secs = 0;
        end
      end
    end else if (m_lock) begin
      if (!match) m_lock = 0;
    end else begin
      if (stop_button) m_missed = 0;
      if (alarm_enable && match) begin
        m_ring = 1; m_used = 0; m_secs = 0;
      end
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic tick();
    one_second = 1'b1; step();
    one_second = 1'b0; step();
  endtask

  task automatic press_stop();
    stop_button = 1'b1; step();
    stop_button = 1'b0;
  endtask

  task automatic press_snooze();
    snooze_button = 1'b1; step();
    snooze_button = 1'b0;
  endtask

  task automatic start_ring();
    current_time = 16'h0729; step();
    current_time = 16'h0730; step();
  endtask

  task automatic test_reset();
    reset = 1'b1; one_second = 0; alarm_enable = 0;
    snooze_button = 0; stop_button = 0;
    current_time = 16'h0000; alarm_time = 16'h0730;
    step(); step();
    checks++;
    if (sound_alarm !== 1'b0) begin
      errors++; $display("FAIL reset_sound got %b want 0", sound_alarm);
    end
    checks++;
    if (snoozing !== 1'b0) begin
      errors++; $display("FAIL reset_snoozing got %b want 0", snoozing);
    end
    checks++;
    if (snooze_left !== 2'd2) begin
      errors++; $display("FAIL reset_left got %0d want 2", snooze_left);
    end
    checks++;
    if (alarm_missed !== 1'b0) begin
      errors++; $display("FAIL reset_missed got %b want 0", alarm_missed);
    end
    reset = 1'b0; step();
  endtask

  task automatic test_basic_ring();
    alarm_enable = 1'b1;
    current_time = 16'h0729; step(); step();
    checks++;
    if (sound_alarm !== 1'b0) begin
      errors++; $display("FAIL ring_premature got %b want 0", sound_alarm);
    end
    current_time = 16'h0730; step();
    checks++;
    if (sound_alarm !== 1'b1) begin
      errors++; $display("FAIL ring_latency got %b want 1", sound_alarm);
    end
    repeat (RS - 1) tick();
    checks++;
    if (sound_alarm !== 1'b1) begin
      errors++; $display("FAIL ring_before_timeout got %b want 1", sound_alarm);
    end
    tick();
    checks++;
    if ({sound_alarm, alarm_missed} !== 2'b01) begin
      errors++;
      $display("FAIL ring_timeout got snd=%b miss=%b want snd=0 miss=1",
               sound_alarm, alarm_missed);
    end
    repeat (3) step();
    checks++;
    if (sound_alarm !== 1'b0) begin
      errors++; $display("FAIL lockout_hold got %b want 0", sound_alarm);
    end
    current_time = 16'h0731; step();
    current_time = 16'h0730; step();
    checks++;
    if (sound_alarm !== 1'b1) begin
      errors++; $display("FAIL idle_rearm got %b want 1", sound_alarm);
    end
    press_stop(); step();
    current_time = 16'h0731; step();
    press_stop(); step();
    checks++;
    if (alarm_missed !== 1'b0) begin
      errors++; $display("FAIL missed_clear got %b want 0", alarm_missed);
    end
  endtask

  task automatic test_stop_lockout();
    start_ring();
    checks++;
    if (sound_alarm !== 1'b1) begin
      errors++; $display("FAIL stop_setup got %b want 1", sound_alarm);
    end
    press_stop();
    checks++;
    if (sound_alarm !== 1'b0) begin
      errors++; $display("FAIL stop_next_clock got %b want 0", sound_alarm);
    end
    repeat (5) step();
    checks++;
    if ({sound_alarm, alarm_missed} !== 2'b00) begin
      errors++;
      $display("FAIL stop_no_rering got snd=%b miss=%b want 0 0",
               sound_alarm, alarm_missed);
    end
    current_time = 16'h0731; step();
    current_time = 16'h0730; step();
    checks++;
    if (sound_alarm !== 1'b1) begin
      errors++; $display("FAIL stop_idle_after_change got %b want 1", sound_alarm);
    end
    press_stop();
    current_time = 16'h0731; step();
  endtask

  task automatic test_snooze_cycle();
    start_ring();
    press_snooze();
    checks++;
    if ({sound_alarm, snoozing, snooze_left} !== 4'b0101) begin
      errors++;
      $display("FAIL snooze1 got snd=%b snz=%b left=%0d want 0 1 1",
               sound_alarm, snoozing, snooze_left);
    end
    current_time = 16'h0731;
    repeat (SS - 1) tick();
    checks++;
    if (snoozing !== 1'b1) begin
      errors++; $display("FAIL snooze_hold got %b want 1", snoozing);
    end
    tick();
    checks++;
    if ({sound_alarm, snoozing} !== 2'b10) begin
      errors++;
      $display("FAIL snooze_expire got snd=%b snz=%b want 1 0",
               sound_alarm, snoozing);
    end
    press_snooze();
    checks++;
    if ({snoozing, snooze_left} !== 3'b100) begin
      errors++;
      $display("FAIL snooze2 got snz=%b left=%0d want 1 0",
               snoozing, snooze_left);
    end
    repeat (SS) tick();
    press_snooze();
    checks++;
    if ({sound_alarm, snoozing, snooze_left} !== 4'b1000) begin
      errors++;
      $display("FAIL snooze3_ignored got snd=%b snz=%b left=%0d want 1 0 0",
               sound_alarm, snoozing, snooze_left);
    end
    repeat (RS) tick();
    checks++;
    if ({sound_alarm, alarm_missed} !== 2'b01) begin
      errors++;
      $display("FAIL snooze_final_timeout got snd=%b miss=%b want 0 1",
               sound_alarm, alarm_missed);
    end
    step();
    press_stop(); step();
  endtask

  task automatic test_priority();
    start_ring();
    stop_button = 1'b1; snooze_button = 1'b1; step();
    stop_button = 1'b0; snooze_button = 1'b0;
    checks++;
    if ({sound_alarm, snoozing, snooze_left} !== 4'b0010) begin
      errors++;
      $display("FAIL prio_stop_snooze got snd=%b snz=%b left=%0d want 0 0 2",
               sound_alarm, snoozing, snooze_left);
    end
    current_time = 16'h0731; step();
    current_time = 16'h0730; step();
    repeat (RS - 1) tick();
    one_second = 1'b1; snooze_button = 1'b1; step();
    one_second = 1'b0; snooze_button = 1'b0;
    checks++;
    if ({snoozing, alarm_missed, snooze_left} !== 4'b1001) begin
      errors++;
      $display("FAIL prio_snooze_timeout got snz=%b miss=%b left=%0d want 1 0 1",
               snoozing, alarm_missed, snooze_left);
    end
    press_stop();
    current_time = 16'h0731; step();
  endtask

  task automatic test_disable_reset();
    start_ring();
    press_snooze();
    alarm_enable = 1'b0; step();
    checks++;
    if ({sound_alarm, snoozing} !== 2'b00) begin
      errors++;
      $display("FAIL disable_snooze got snd=%b snz=%b want 0 0",
               sound_alarm, snoozing);
    end
    alarm_enable = 1'b1;
    start_ring();
    press_snooze();
    repeat (SS) tick();
    checks++;
    if ({sound_alarm, snooze_left} !== 3'b101) begin
      errors++;
      $display("FAIL reset_setup got snd=%b left=%0d want 1 1",
               sound_alarm, snooze_left);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sound_alarm, snooze_left} !== 3'b010) begin
      errors++;
      $display("FAIL reset_async got snd=%b left=%0d want 0 2",
               sound_alarm, snooze_left);
    end
    step();
    reset = 1'b0; step();
    checks++;
    if (sound_alarm !== 1'b1) begin
      errors++; $display("FAIL reset_release_ring got %b want 1", sound_alarm);
    end
    press_stop();
    current_time = 16'h0731; step();
  endtask

  task automatic test_random();
    logic [15:0] times [3];
    logic [1:0]  exp_left;
    times[0] = 16'h1159; times[1] = 16'h1200; times[2] = 16'h1201;
    alarm_time = 16'h1200;
    reset = 1'b1; step();
    reset = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(19) == 0) current_time = times[$urandom_range(2)];
      alarm_enable  = ($urandom_range(39) != 0);
      snooze_button = ($urandom_range(11) == 0);
      stop_button   = ($urandom_range(39) == 0);
      one_second    = ($urandom_range(2) == 0);
      reset         = ($urandom_range(799) == 0);
      step();
      exp_left = 2'(MS - m_used);
      checks++;
      if ({sound_alarm, snoozing, snooze_left, alarm_missed} !==
          {m_ring, m_snz, exp_left, m_missed}) begin
        errors++;
        $display("FAIL random_cycle_%0d got snd=%b snz=%b left=%0d miss=%b want %b %b %0d %b",
                 i, sound_alarm, snoozing, snooze_left, alarm_missed,
                 m_ring, m_snz, exp_left, m_missed);
      end
    end
    reset = 1'b0; one_second = 0; snooze_button = 0; stop_button = 0;
  endtask

  initial begin
    test_reset();
    test_basic_ring();
    test_stop_lockout();
    test_snooze_cycle();
    test_priority();
    test_disable_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
